// File: rtl/rk_job_scheduler.sv
// -----------------------------------------------------------------------------
// rk_job_scheduler
//
// Round-robin scheduler that shares a single RK step engine among R ODE-solve
// requesters. A job (x0, y0, h, step count) is accepted from one requester,
// the engine is started once per RK step with the current (x, y, h), the
// engine's y result is fed back, and x advances by h after every step. When
// the step count is exhausted (or the job aborts) the final y is returned
// tagged with the requester index.
//
// Ports
//   clk, rstn        clock; asynchronous active-low reset
//   i_req_valid[R]   per-requester job request
//   o_req_ready[R]   one-hot accept, asserted only in the GRANT cycle
//   i_req_x0/y0/h    R packed WIDTH-bit signed operands (requester r at [r*WIDTH +: WIDTH])
//   i_req_steps      R packed SW-bit step counts (requester r at [r*SW +: SW])
//   o_eng_start      one-cycle pulse: engine begins a step
//   o_eng_x/y/h      engine operands, stable from start until done
//   i_eng_done       one-cycle pulse: step complete, i_eng_y valid
//   o_rsp_valid      result available; id/y/err held until i_rsp_ready
//   o_rsp_id/y/err   requester index, final y, abort flag
//   o_busy           high in every state except IDLE
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module rk_job_scheduler #(
  parameter  int WIDTH    = 32,
  parameter  int R        = 4,
  parameter  int MAX_STEP = 1000,
  parameter  int TIMEOUT  = 4096,
  localparam int SW       = $clog2(MAX_STEP + 1),
  localparam int IDW      = (R > 1) ? $clog2(R) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [R-1:0]       i_req_valid,
  output logic [R-1:0]       o_req_ready,
  input  logic [R*WIDTH-1:0] i_req_x0,
  input  logic [R*WIDTH-1:0] i_req_y0,
  input  logic [R*WIDTH-1:0] i_req_h,
  input  logic [R*SW-1:0]    i_req_steps,
  output logic               o_eng_start,
  output logic [WIDTH-1:0]   o_eng_x,
  output logic [WIDTH-1:0]   o_eng_y,
  output logic [WIDTH-1:0]   o_eng_h,
  input  logic               i_eng_done,
  input  logic [WIDTH-1:0]   i_eng_y,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [IDW-1:0]     o_rsp_id,
  output logic [WIDTH-1:0]   o_rsp_y,
  output logic               o_rsp_err,
  output logic               o_busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Job context
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_h;
  logic [SW-1:0]    r_rem;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_rr;
  logic             r_err;
  logic [TW-1:0]    r_tmo;

  // Per-requester views of the packed request buses
  logic [WIDTH-1:0] w_x0    [R];
  logic [WIDTH-1:0] w_y0    [R];
  logic [WIDTH-1:0] w_h0    [R];
  logic [SW-1:0]    w_steps [R];

  genvar gi;
  generate
    for (gi = 0; gi < R; gi++) begin : g_unpack
      assign w_x0[gi]    = i_req_x0[gi*WIDTH +: WIDTH];
      assign w_y0[gi]    = i_req_y0[gi*WIDTH +: WIDTH];
      assign w_h0[gi]    = i_req_h[gi*WIDTH +: WIDTH];
      assign w_steps[gi] = i_req_steps[gi*SW +: SW];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin pick: lowest valid index strictly above r_rr wins; if there is
  // none, wrap around to the lowest valid index at or below r_rr. The second
  // loop overrides the first so "above r_rr" always has priority.
  // ---------------------------------------------------------------------------
  logic           w_gnt_any;
  logic [IDW-1:0] w_gnt_idx;

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (i_req_valid[i] && (IDW'(i) <= r_rr)) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IDW'(i);
      end
    end
    for (int i = R - 1; i >= 0; i--) begin
      if (i_req_valid[i] && (IDW'(i) > r_rr)) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IDW'(i);
      end
    end
  end

  logic [WIDTH-1:0] w_sel_x0;
  logic [WIDTH-1:0] w_sel_y0;
  logic [WIDTH-1:0] w_sel_h;
  logic [SW-1:0]    w_sel_steps;
  logic             w_steps_zero;
  logic             w_steps_over;
  logic             w_last_step;
  logic             w_tmo_hit;

  assign w_sel_x0     = w_x0[w_gnt_idx];
  assign w_sel_y0     = w_y0[w_gnt_idx];
  assign w_sel_h      = w_h0[w_gnt_idx];
  assign w_sel_steps  = w_steps[w_gnt_idx];
  assign w_steps_zero = (w_sel_steps == '0);
  // The step field can encode values above MAX_STEP; such jobs are rejected.
  assign w_steps_over = (32'(w_sel_steps) > 32'(MAX_STEP));
  // r_rem counts steps still owed including the one in flight.
  assign w_last_step  = (r_rem == SW'(1));
  // WAIT lasts at most TIMEOUT cycles without a done pulse.
  assign w_tmo_hit    = (r_tmo == TW'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    o_req_ready  = '0;
    o_eng_start  = 1'b0;
    o_rsp_valid  = 1'b0;
    o_busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (|i_req_valid) begin
          w_state_next = S_GRANT;
        end
      end
      S_GRANT: begin
        // A requester may have dropped valid since IDLE; with nothing left to
        // grant, fall back to IDLE rather than accept a phantom job.
        if (w_gnt_any) begin
          o_req_ready[w_gnt_idx] = 1'b1;
          if (w_steps_zero || w_steps_over) begin
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_START;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_START: begin
        o_eng_start  = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving in the same cycle as the timeout still counts.
        if (i_eng_done) begin
          w_state_next = w_last_step ? S_RESP : S_START;
        end else if (w_tmo_hit) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job context datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x   <= '0;
      r_y   <= '0;
      r_h   <= '0;
      r_rem <= '0;
      r_id  <= '0;
      r_rr  <= IDW'(R - 1);
      r_err <= 1'b0;
      r_tmo <= '0;
    end else begin
      case (r_state)
        S_GRANT: begin
          if (w_gnt_any) begin
            r_x   <= w_sel_x0;
            r_y   <= w_sel_y0;
            r_h   <= w_sel_h;
            r_rem <= w_sel_steps;
            r_id  <= w_gnt_idx;
            r_rr  <= w_gnt_idx;
            r_err <= w_steps_over;
          end
        end
        S_START: begin
          r_tmo <= '0;
        end
        S_WAIT: begin
          if (i_eng_done) begin
            r_y   <= i_eng_y;
            r_x   <= r_x + r_h;        // plain modular wrap, no saturation
            r_rem <= r_rem - 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            if (w_tmo_hit) begin
              r_err <= 1'b1;           // y keeps the last committed step
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_eng_x   = r_x;
  assign o_eng_y   = r_y;
  assign o_eng_h   = r_h;
  assign o_rsp_id  = r_id;
  assign o_rsp_y   = r_y;
  assign o_rsp_err = r_err;

endmodule
